// File: rtl/p4_split_pkg.sv
// rtl/p4_split_pkg.sv - shared types and constants for the P4 ingress split path
package p4_split_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      XFER = 1'b1
   } arb_state_t;

   localparam int TDATA_NUM_BYTES      = 64;
   localparam int USER_META_DATA_WIDTH = 9;

   // Bit position of the source port index inside user_metadata
   localparam int META_PORT_ID_LSB = 0;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin priority selector
module rr_pick #(
   parameter int N = 4,
   parameter int W = $clog2(N)
) (
   input  logic [N-1:0] req_i,
   input  logic [W-1:0] ptr_i,
   output logic [W-1:0] idx_o,
   output logic         any_o
);

   // First requester at or after ptr_i, scanning upward and wrapping modulo N
   always_comb begin
      idx_o = '0;
      any_o = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (!any_o && req_i[(int'(ptr_i) + i) % N]) begin
            any_o = 1'b1;
            idx_o = W'((int'(ptr_i) + i) % N);
         end
      end
   end

endmodule

// File: rtl/p4_ingress_arbiter.sv
// rtl/p4_ingress_arbiter.sv - packet-granular round-robin merge of ingress streams
module p4_ingress_arbiter #(
   parameter int NUM_PORTS            = 4,
   parameter int TDATA_NUM_BYTES      = p4_split_pkg::TDATA_NUM_BYTES,
   parameter int USER_META_DATA_WIDTH = p4_split_pkg::USER_META_DATA_WIDTH
) (
   input  logic                                   s_axis_aclk,
   input  logic                                   s_axis_areset,
   input  logic [NUM_PORTS*TDATA_NUM_BYTES*8-1:0] s_axis_tdata,
   input  logic [NUM_PORTS*TDATA_NUM_BYTES-1:0]   s_axis_tkeep,
   input  logic [NUM_PORTS-1:0]                   s_axis_tvalid,
   input  logic [NUM_PORTS-1:0]                   s_axis_tlast,
   output logic [NUM_PORTS-1:0]                   s_axis_tready,
   output logic [TDATA_NUM_BYTES*8-1:0]           m_axis_tdata,
   output logic [TDATA_NUM_BYTES-1:0]             m_axis_tkeep,
   output logic                                   m_axis_tvalid,
   output logic                                   m_axis_tlast,
   input  logic                                   m_axis_tready,
   output logic [USER_META_DATA_WIDTH-1:0]        user_metadata_out,
   output logic                                   user_metadata_valid,
   output logic [NUM_PORTS-1:0]                   pkt_done
);

   import p4_split_pkg::*;

   localparam int PORT_ID_WIDTH = $clog2(NUM_PORTS);
   localparam int DW            = TDATA_NUM_BYTES * 8;
   localparam logic [PORT_ID_WIDTH-1:0] LAST_PORT = PORT_ID_WIDTH'(NUM_PORTS - 1);

   if (USER_META_DATA_WIDTH < PORT_ID_WIDTH) begin : g_meta_too_narrow
      $error("USER_META_DATA_WIDTH must hold the port index");
   end

   arb_state_t               state_q, state_d;
   logic [PORT_ID_WIDTH-1:0] grant_q, grant_d;
   logic [PORT_ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
   logic                     sop_q, sop_d;
   logic [PORT_ID_WIDTH-1:0] pick_idx;
   logic                     pick_any;

   rr_pick #(
      .N (NUM_PORTS),
      .W (PORT_ID_WIDTH)
   ) u_rr_pick (
      .req_i (s_axis_tvalid),
      .ptr_i (rr_ptr_q),
      .idx_o (pick_idx),
      .any_o (pick_any)
   );

   // State, grant, round-robin pointer and start-of-packet registers
   always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
      if (s_axis_areset) begin
         state_q  <= IDLE;
         grant_q  <= '0;
         rr_ptr_q <= '0;
         sop_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         rr_ptr_q <= rr_ptr_d;
         sop_q    <= sop_d;
      end
   end

   // Next-state logic and the combinational pass-through of the granted port
   always_comb begin
      state_d             = state_q;
      grant_d             = grant_q;
      rr_ptr_d            = rr_ptr_q;
      sop_d               = sop_q;
      s_axis_tready       = '0;
      m_axis_tdata        = '0;
      m_axis_tkeep        = '0;
      m_axis_tvalid       = 1'b0;
      m_axis_tlast        = 1'b0;
      user_metadata_valid = 1'b0;
      pkt_done            = '0;
      case (state_q)
         IDLE: begin
            if (pick_any) begin
               grant_d = pick_idx;
               sop_d   = 1'b1;
               state_d = XFER;
            end
         end
         XFER: begin
            m_axis_tdata           = s_axis_tdata[int'(grant_q)*DW +: DW];
            m_axis_tkeep           = s_axis_tkeep[int'(grant_q)*TDATA_NUM_BYTES +: TDATA_NUM_BYTES];
            m_axis_tvalid          = s_axis_tvalid[grant_q];
            m_axis_tlast           = s_axis_tlast[grant_q];
            s_axis_tready[grant_q] = m_axis_tready;
            user_metadata_valid    = sop_q & m_axis_tvalid;
            if (m_axis_tvalid && m_axis_tready) begin
               sop_d = 1'b0;
               if (m_axis_tlast) begin
                  pkt_done[grant_q] = 1'b1;
                  rr_ptr_d          = (grant_q == LAST_PORT) ? '0 : grant_q + PORT_ID_WIDTH'(1);
                  state_d           = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Metadata carries the granted port index, zero-extended, for the whole packet
   always_comb begin
      user_metadata_out = '0;
      user_metadata_out[META_PORT_ID_LSB +: PORT_ID_WIDTH] = grant_q;
   end

endmodule

// File: tb/tb_p4_ingress_arbiter.sv
// tb/tb_p4_ingress_arbiter.sv - scoreboard bench for p4_ingress_arbiter
module tb_p4_ingress_arbiter;

   localparam int NP = 4;
   localparam int NB = 4;
   localparam int DW = NB * 8;
   localparam int MW = 9;
   localparam int TR = 64;

   typedef struct {
      logic [MW-1:0] meta;
      logic [DW-1:0] data;
      logic [NB-1:0] keep;
      logic          last;
   } beat_t;

   logic              clk;
   logic              rst;
   logic [NP*DW-1:0]  s_tdata;
   logic [NP*NB-1:0]  s_tkeep;
   logic [NP-1:0]     s_tvalid;
   logic [NP-1:0]     s_tlast;
   logic [NP-1:0]     s_tready;
   logic [DW-1:0]     m_tdata;
   logic [NB-1:0]     m_tkeep;
   logic              m_tvalid;
   logic              m_tlast;
   logic              m_tready;
   logic [MW-1:0]     meta;
   logic              umv;
   logic [NP-1:0]     pkt_done;

   beat_t      src_q[NP][$];
   beat_t      exp_q[$];
   int         en_cycle[NP];
   logic [TR-1:0] rdy_mask;

   logic          tr_vld[TR];
   logic          tr_last[TR];
   logic          tr_umv[TR];
   logic [MW-1:0] tr_meta[TR];
   logic [NP-1:0] tr_srdy[TR];
   logic [NP-1:0] tr_done[TR];
   logic [DW-1:0] tr_data[TR];
   logic          tr_fire[TR];

   int n_cmp = 0;
   int n_bad = 0;
   int pkt_id = 0;

   p4_ingress_arbiter #(
      .NUM_PORTS            (NP),
      .TDATA_NUM_BYTES      (NB),
      .USER_META_DATA_WIDTH (MW)
   ) dut (
      .s_axis_aclk         (clk),
      .s_axis_areset       (rst),
      .s_axis_tdata        (s_tdata),
      .s_axis_tkeep        (s_tkeep),
      .s_axis_tvalid       (s_tvalid),
      .s_axis_tlast        (s_tlast),
      .s_axis_tready       (s_tready),
      .m_axis_tdata        (m_tdata),
      .m_axis_tkeep        (m_tkeep),
      .m_axis_tvalid       (m_tvalid),
      .m_axis_tlast        (m_tlast),
      .m_axis_tready       (m_tready),
      .user_metadata_out   (meta),
      .user_metadata_valid (umv),
      .pkt_done            (pkt_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic drive(input int c);
      for (int p = 0; p < NP; p++) begin
         if (src_q[p].size() > 0 && c >= en_cycle[p]) begin
            s_tvalid[p]          = 1'b1;
            s_tdata[p*DW +: DW]  = src_q[p][0].data;
            s_tkeep[p*NB +: NB]  = src_q[p][0].keep;
            s_tlast[p]           = src_q[p][0].last;
         end else begin
            s_tvalid[p]          = 1'b0;
            s_tdata[p*DW +: DW]  = '0;
            s_tkeep[p*NB +: NB]  = '0;
            s_tlast[p]           = 1'b0;
         end
      end
      m_tready = rdy_mask[c];
   endtask

   task automatic add_pkt(input int port, input int nbeats);
      beat_t e;
      for (int b = 0; b < nbeats; b++) begin
         e.meta = MW'(port);
         e.data = {4'(port), 8'(pkt_id), 8'(b), 12'hA5C};
         e.keep = (b == nbeats - 1) ? 4'h3 : 4'hF;
         e.last = (b == nbeats - 1);
         src_q[port].push_back(e);
         exp_q.push_back(e);
      end
      pkt_id++;
   endtask

   task automatic run(input int n);
      beat_t e;
      logic [NP-1:0] fired;
      for (int c = 0; c < n; c++) begin
         @(negedge clk);
         tr_vld[c]  = m_tvalid;
         tr_last[c] = m_tlast;
         tr_umv[c]  = umv;
         tr_meta[c] = meta;
         tr_srdy[c] = s_tready;
         tr_done[c] = pkt_done;
         tr_data[c] = m_tdata;
         tr_fire[c] = m_tvalid & m_tready;
         if (m_tvalid && m_tready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_bad++;
               $display("FAIL sb_extra: cycle %0d got data %h meta %0d, required no beat", c, m_tdata, meta);
            end else begin
               e = exp_q.pop_front();
               if ({meta, m_tdata, m_tkeep, m_tlast} !== {e.meta, e.data, e.keep, e.last}) begin
                  n_bad++;
                  $display("FAIL sb_beat: cycle %0d got meta %0d data %h keep %h last %b, required meta %0d data %h keep %h last %b",
                           c, meta, m_tdata, m_tkeep, m_tlast, e.meta, e.data, e.keep, e.last);
               end
            end
         end
         fired = s_tvalid & s_tready;
         @(posedge clk);
         #1;
         for (int p = 0; p < NP; p++)
            if (fired[p] && src_q[p].size() > 0) void'(src_q[p].pop_front());
         drive(c + 1);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      for (int p = 0; p < NP; p++) begin
         src_q[p].delete();
         en_cycle[p] = 0;
      end
      exp_q.delete();
      rdy_mask = '1;
      drive(0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic check_sb_empty(input string name);
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL %s_drain: %0d beats outstanding, required 0", name, exp_q.size());
      end
   endtask

   task automatic test_reset();
      rst      = 1'b1;
      s_tvalid = '1;
      s_tlast  = '0;
      s_tdata  = '1;
      s_tkeep  = '1;
      m_tready = 1'b1;
      @(negedge clk);
      n_cmp++;
      if ({s_tready, m_tvalid, umv, pkt_done} !== '0) begin
         n_bad++;
         $display("FAIL reset_ctrl: s_tready %b m_tvalid %b umv %b pkt_done %b, required all 0", s_tready, m_tvalid, umv, pkt_done);
      end
      n_cmp++;
      if ({meta, m_tdata, m_tlast} !== '0) begin
         n_bad++;
         $display("FAIL reset_data: meta %0d tdata %h tlast %b, required 0", meta, m_tdata, m_tlast);
      end
      do_reset();
   endtask

   task automatic test_single_port();
      logic exp_v[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      do_reset();
      add_pkt(2, 3);
      drive(0);
      run(6);
      for (int c = 0; c < 5; c++) begin
         n_cmp++;
         if (tr_vld[c] !== exp_v[c]) begin
            n_bad++;
            $display("FAIL sp_valid: cycle %0d m_tvalid %b, required %b", c, tr_vld[c], exp_v[c]);
         end
      end
      n_cmp++;
      if ({tr_umv[1], tr_umv[2], tr_umv[3], tr_meta[1]} !== {3'b100, 9'd2}) begin
         n_bad++;
         $display("FAIL sp_meta: umv c1..3 %b%b%b meta %0d, required 100 meta 2", tr_umv[1], tr_umv[2], tr_umv[3], tr_meta[1]);
      end
      n_cmp++;
      if ({tr_done[2], tr_done[3], tr_done[4]} !== {4'b0000, 4'b0100, 4'b0000}) begin
         n_bad++;
         $display("FAIL sp_done: pkt_done c2..4 %b %b %b, required 0000 0100 0000", tr_done[2], tr_done[3], tr_done[4]);
      end
      check_sb_empty("sp");
   endtask

   task automatic test_fairness();
      int fires;
      do_reset();
      for (int r = 0; r < 2; r++)
         for (int p = 0; p < NP; p++) add_pkt(p, 2);
      drive(0);
      run(26);
      fires = 0;
      for (int c = 0; c < 24; c++) fires += int'(tr_fire[c]);
      n_cmp++;
      if (fires != 16) begin
         n_bad++;
         $display("FAIL rr_beats: %0d beats in 24 cycles, required 16", fires);
      end
      n_cmp++;
      if ({tr_done[23], tr_vld[24]} !== {4'b1000, 1'b0}) begin
         n_bad++;
         $display("FAIL rr_end: pkt_done c23 %b m_tvalid c24 %b, required 1000 0", tr_done[23], tr_vld[24]);
      end
      check_sb_empty("rr");
   endtask

   task automatic test_backpressure();
      logic [DW-1:0] d0;
      d0 = {4'd1, 8'(pkt_id), 8'd0, 12'hA5C};
      add_pkt(1, 4);
      rdy_mask = '1;
      for (int c = 1; c < TR; c++) rdy_mask[c] = (c % 2 == 0);
      drive(0);
      run(11);
      for (int c = 1; c <= 8; c++) begin
         n_cmp++;
         if (tr_srdy[c] !== (rdy_mask[c] ? 4'b0010 : 4'b0000)) begin
            n_bad++;
            $display("FAIL bp_ready: cycle %0d s_tready %b, required %b", c, tr_srdy[c], rdy_mask[c] ? 4'b0010 : 4'b0000);
         end
      end
      n_cmp++;
      if (tr_data[1] !== d0 || tr_data[2] !== d0) begin
         n_bad++;
         $display("FAIL bp_hold: data c1 %h c2 %h, required %h", tr_data[1], tr_data[2], d0);
      end
      n_cmp++;
      if ({tr_umv[1], tr_umv[2], tr_umv[3]} !== 3'b110) begin
         n_bad++;
         $display("FAIL bp_umv: umv c1..3 %b%b%b, required 110", tr_umv[1], tr_umv[2], tr_umv[3]);
      end
      n_cmp++;
      if ({tr_done[8], tr_vld[9]} !== {4'b0010, 1'b0}) begin
         n_bad++;
         $display("FAIL bp_done: pkt_done c8 %b m_tvalid c9 %b, required 0010 0", tr_done[8], tr_vld[9]);
      end
      rdy_mask = '1;
      check_sb_empty("bp");
   endtask

   task automatic test_sticky_grant();
      do_reset();
      add_pkt(3, 3);
      add_pkt(0, 2);
      en_cycle[0] = 2;
      drive(0);
      run(9);
      n_cmp++;
      if ({tr_meta[2], tr_srdy[2]} !== {9'd3, 4'b1000}) begin
         n_bad++;
         $display("FAIL sg_hold: meta %0d s_tready %b, required 3 1000", tr_meta[2], tr_srdy[2]);
      end
      n_cmp++;
      if ({tr_done[3], tr_vld[4]} !== {4'b1000, 1'b0}) begin
         n_bad++;
         $display("FAIL sg_gap: pkt_done c3 %b m_tvalid c4 %b, required 1000 0", tr_done[3], tr_vld[4]);
      end
      n_cmp++;
      if ({tr_vld[5], tr_umv[5], tr_meta[5], tr_done[6]} !== {2'b11, 9'd0, 4'b0001}) begin
         n_bad++;
         $display("FAIL sg_next: vld %b umv %b meta %0d done c6 %b, required 1 1 0 0001", tr_vld[5], tr_umv[5], tr_meta[5], tr_done[6]);
      end
      en_cycle[0] = 0;
      check_sb_empty("sg");
   endtask

   task automatic test_single_beat();
      add_pkt(1, 1);
      drive(0);
      run(3);
      n_cmp++;
      if ({tr_vld[1], tr_umv[1], tr_last[1], tr_done[1], tr_meta[1]} !== {3'b111, 4'b0010, 9'd1}) begin
         n_bad++;
         $display("FAIL sb1_same: vld %b umv %b last %b done %b meta %0d, required 1 1 1 0010 1",
                  tr_vld[1], tr_umv[1], tr_last[1], tr_done[1], tr_meta[1]);
      end
      n_cmp++;
      if (tr_vld[2] !== 1'b0) begin
         n_bad++;
         $display("FAIL sb1_idle: m_tvalid c2 %b, required 0", tr_vld[2]);
      end
      check_sb_empty("sb1");
   endtask

   task automatic test_reset_mid_packet();
      add_pkt(2, 5);
      drive(0);
      run(2);
      n_cmp++;
      if ({m_tvalid, meta} !== {1'b1, 9'd2}) begin
         n_bad++;
         $display("FAIL rm_pre: m_tvalid %b meta %0d, required 1 2", m_tvalid, meta);
      end
      #2;
      rst = 1'b1;
      #1;
      n_cmp++;
      if ({m_tvalid, s_tready, umv, pkt_done, m_tlast, m_tdata} !== '0) begin
         n_bad++;
         $display("FAIL rm_async: m_tvalid %b s_tready %b umv %b done %b last %b data %h, required all 0",
                  m_tvalid, s_tready, umv, pkt_done, m_tlast, m_tdata);
      end
      do_reset();
      for (int p = 0; p < NP; p++) add_pkt(p, 1);
      drive(0);
      run(10);
      n_cmp++;
      if ({tr_umv[1], tr_meta[1]} !== {1'b1, 9'd0}) begin
         n_bad++;
         $display("FAIL rm_restart: umv %b meta %0d, required 1 0", tr_umv[1], tr_meta[1]);
      end
      check_sb_empty("rm");
   endtask

   initial begin
      rdy_mask = '1;
      for (int p = 0; p < NP; p++) en_cycle[p] = 0;
      test_reset();
      test_single_port();
      test_fairness();
      test_backpressure();
      test_sticky_grant();
      test_single_beat();
      test_reset_mid_packet();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/p4_ingress_arbiter.md
# p4_ingress_arbiter

Packet-granular round-robin arbiter that merges NUM_PORTS AXI-Stream ingress channels into the single slave stream of vitis_net_p4_0. It generates the per-packet user_metadata_in word, carrying the source port index, and presents it with the first beat. It never interleaves beats of different packets. It sits directly upstream of the P4 pipeline.

## Interface
- NUM_PORTS, 4: number of ingress channels, 2..16
- TDATA_NUM_BYTES, 64: stream width in bytes; must match the P4 instance
- USER_META_DATA_WIDTH, 9: metadata width; must be ≥ PORT_ID_WIDTH
- PORT_ID_WIDTH, $clog2(NUM_PORTS): derived, not overridden
- s_axis_aclk  in  1  sole clock
- s_axis_areset  in  1  asynchronous, active-high reset
- s_axis_tdata  in  NUM_PORTS×TDATA_NUM_BYTES*8  per-port data (packed array)
- s_axis_tkeep  in  NUM_PORTS×TDATA_NUM_BYTES  per-port byte enables
- s_axis_tvalid / s_axis_tlast  in  NUM_PORTS  per-port valid / end-of-packet
- s_axis_tready  out  NUM_PORTS  per-port ready
- m_axis_tdata / m_axis_tkeep / m_axis_tvalid / m_axis_tlast  out  as P4 slave  to P4 s_axis_*
- m_axis_tready  in  1  from P4 s_axis_tready
- user_metadata_out  out  USER_META_DATA_WIDTH  to P4 user_metadata_in; zero-extended {0, grant_idx}
- user_metadata_valid  out  1  to P4 user_metadata_in_valid
- pkt_done  out  NUM_PORTS  one-cycle pulse per port on the accepted tlast beat

## Operation
- FSM states: IDLE and XFER.
- IDLE:
  - All s_axis_tready = 0; m_axis_tvalid = 0.
  - If any s_axis_tvalid is high, latch grant_idx = the first requesting port at or after rr_ptr, scanning upward and wrapping modulo NUM_PORTS.
  - Set sop = 1 and go to XFER.
- XFER:
  - m_axis_tdata, tkeep, tvalid and tlast = s_axis_*[grant_idx]. Combinational pass-through, no data register.
  - s_axis_tready[grant_idx] = m_axis_tready; all other readies are 0.
  - user_metadata_valid = sop & m_axis_tvalid. user_metadata_out = {0, grant_idx}; it is held at this value for the whole packet.
  - sop clears on the first accepted beat (m_axis_tvalid & m_axis_tready).
  - On an accepted beat with tlast: pulse pkt_done[grant_idx], set rr_ptr = grant_idx+1 (wrapping modulo NUM_PORTS; NUM_PORTS−1 wraps to 0), go to IDLE.
- Grant is sticky for the packet. A granted port dropping tvalid mid-packet stalls the output; no re-arbitration happens.
- Single-beat packets (tlast on the first beat) assert user_metadata_valid and pkt_done in the same cycle.
- Requests from non-granted ports have no effect until IDLE. Fairness: with all ports busy, service order is strictly 0,1,2,…,N−1,0.

## Timing
- Reset values: state = IDLE, rr_ptr = 0, grant_idx = 0, sop = 0, all s_axis_tready = 0, m_axis_tvalid = 0, user_metadata_valid = 0, pkt_done = 0. m_axis_tdata, tkeep and tlast are don't-care while m_axis_tvalid = 0; drive them 0 in IDLE.
- Arbitration costs exactly one IDLE cycle per packet. A request seen in cycle t makes its first beat visible on m_axis in cycle t+1.
- Throughput: a packet of B beats occupies ≥ B+1 cycles.
- Data path latency is 0 cycles in XFER, with ready propagated combinationally.
- m_axis_tvalid, once high, only drops after a handshake or when the source port deasserts. The block introduces no invalid AXIS drops.
- Asserting reset mid-packet aborts the packet and forces all outputs to their reset values immediately. No tlast is emitted downstream; recovery is the system's responsibility.

## Structure
- Shared package p4_split_pkg holds: the arb_state_t enum (IDLE, XFER), TDATA_NUM_BYTES, USER_META_DATA_WIDTH, and the metadata field layout (port-id LSB position).
- Sub-module rr_pick: a combinational round-robin priority selector (req vector + rr_ptr → index, any). It is reused by future egress schedulers.
- Top level: FSM, grant/sop/rr_ptr registers, output mux.

## Test plan
- Single port 2, 3-beat packet, m_axis_tready = 1:
  - Cycle 0 is IDLE; beats appear cycles 1–3.
  - user_metadata_out = 9'd2 with user_metadata_valid only in cycle 1.
  - pkt_done[2] pulses in cycle 3.
- All 4 ports continuously offering 2-beat packets: output port order is 0,1,2,3,0,1,… with no beat interleaving. 8 packets take 24 cycles.
- m_axis_tready toggled 1,0,1,0 during a 4-beat packet from port 1:
  - s_axis_tready[1] mirrors m_axis_tready exactly.
  - Data is unchanged while stalled; user_metadata_valid stays high until the first acceptance.
- Port 3 packet in progress while port 0 requests: port 0 waits for port 3 tlast, is granted next (rr_ptr wrapped to 0), and its metadata = 9'd0.
- Single-beat packet from port 1: user_metadata_valid, m_axis_tlast and pkt_done[1] are all high in the same cycle.
- Reset asserted in the second beat of a 5-beat packet: all outputs drop asynchronously, and after release the next grant starts from port 0.
